// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: state encoding, frame size and bit timing.
// Imported by the transmitter now and by the receiver later.
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// A clear realigns the bit period to the current edge.
module uart_baud_timer #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] r_cnt;

    assign bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FWFT FIFO drain serialising each byte as an 8N1 UART frame.
// Back-to-back frames pop at the stop bit end with no idle gap.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

    tx_state_t             r_state, w_state;
    logic [2:0]            r_bit_cnt, w_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift;
    logic                  r_tx, w_tx;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  w_bit_end;
    logic                  w_pop;

    uart_baud_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (w_pop),
        .bit_end(w_bit_end)
    );

    // Gated by reset so no pop strobe is seen while the block is held
    assign w_pop = reset_n && !fifo_empty &&
                   ((r_state == IDLE) ||
                    (r_state == STOP && w_bit_end));

    assign fifo_read_en = w_pop;
    assign tx           = r_tx;
    assign busy         = r_busy;
    assign tx_done      = r_done;

    always_comb begin
        w_state   = r_state;
        w_bit_cnt = r_bit_cnt;
        w_shift   = r_shift;
        w_tx      = r_tx;
        w_busy    = r_busy;
        w_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state = START;
                    w_shift = fifo_data;
                    w_tx    = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state   = DATA;
                    w_bit_cnt = 3'd0;
                    w_tx      = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state = STOP;
                        w_tx    = 1'b1;
                    end else begin
                        w_shift   = r_shift >> 1;
                        w_bit_cnt = r_bit_cnt + 3'd1;
                        w_tx      = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_done = 1'b1;
                    if (w_pop) begin
                        w_state = START;
                        w_shift = fifo_data;
                        w_tx    = 1'b0;
                    end else begin
                        w_state = IDLE;
                        w_busy  = 1'b0;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bit_cnt <= w_bit_cnt;
            r_shift   <= w_shift;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

endmodule
